// File: rtl/load_store_unit.sv
// Data-memory access stage: req/ack transaction with byte-lane steering and load extension.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of truncating.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;

    // Command decode on the raw inputs, used only at acceptance.
    logic        is_load, is_store, legal, misaligned, trap;
    logic [1:0]  lane_new;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        legal    = 1'b0;
        if (is_load) begin
            case (func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else if (is_store) begin
            legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
        end
        misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                     ((func3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        trap = misaligned;
`else
        trap = 1'b0;
`endif
        case (func3[1:0])
            2'b00: begin
                lane_new  = addr[1:0];
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_new  = {addr[1], 1'b0};
                be_new    = 4'b0011 << {addr[1], 1'b0};
                wdata_new = {2{wdata[15:0]}};
            end
            default: begin
                lane_new  = 2'b00;
                be_new    = 4'b1111;
                wdata_new = wdata;
            end
        endcase
    end

    // Lane extraction of the returned word using the latched command.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    always_comb begin
        rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (start && (is_load || is_store)) begin
                    if (!legal || trap) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        addr_d  = {addr[31:2], 2'b00};
                        wdata_d = wdata_new;
                        be_d    = be_new;
                        we_d    = is_store;
                        f3_d    = func3;
                        lane_d  = lane_new;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = load_val;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit (TIMEOUT=4), plus reset/busy corner sequences.
module tb_load_store_unit;

    localparam int TP = 4;

    logic        clk = 1'b0;
    logic        rst, start, mem_ack;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TP)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .func3(func3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    // ack: >=0 ack delay in cycles, -1 no ack (timeout), -2 error without access
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          ack;
        logic        e_err;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_we;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        opcode = v.op; func3 = v.f3; addr = v.addr; wdata = v.wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opcode = 7'h00; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        check($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd1);
        if (v.ack == -2) begin
            check($sformatf("v%0d done_err_path", idx), {31'd0, done}, 32'd1);
            check($sformatf("v%0d req_err_path", idx), {31'd0, mem_req}, 32'd0);
        end else begin
            check($sformatf("v%0d req", idx), {31'd0, mem_req}, 32'd1);
            check($sformatf("v%0d done_early", idx), {31'd0, done}, 32'd0);
            check($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
            check($sformatf("v%0d mem_be", idx), {28'd0, mem_be}, {28'd0, v.e_be});
            check($sformatf("v%0d mem_we", idx), {31'd0, mem_we}, {31'd0, v.e_we});
            if (v.e_we)
                check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wd);
            if (v.ack == -1) begin
                repeat (TP - 1) begin
                    @(negedge clk);
                    check($sformatf("v%0d req_hold", idx), {30'd0, mem_req, done}, 32'd2);
                end
                @(negedge clk);
            end else begin
                repeat (v.ack) begin
                    @(negedge clk);
                    check($sformatf("v%0d req_wait", idx), {30'd0, mem_req, done}, 32'd2);
                end
                mem_ack = 1'b1; mem_rdata = v.mrd;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = 32'h0;
            end
            check($sformatf("v%0d req_drop", idx), {31'd0, mem_req}, 32'd0);
            check($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
        end
        check($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.e_err});
        check($sformatf("v%0d rdata", idx), rdata, v.e_rd);
        @(negedge clk);
        check($sformatf("v%0d idle_after", idx), {30'd0, busy, done}, 32'd0);
        $display("vec %0d op=%b f3=%b addr=%08h rdata=%08h err=%0b", idx, v.op, v.f3, v.addr, rdata, v.e_err);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ack = 1'b0; opcode = 7'h0; func3 = 3'h0;
        addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;

        //            op  f3     addr          wd            mrd          ack err e_addr        be       e_wd          we    e_rd
        vecs[0]  = '{LD, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80};
        vecs[1]  = '{LD, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0100, 4'b1000, 32'h0,        1'b0, 32'h0000_0080};
        vecs[2]  = '{ST, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        2, 0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0080};
        vecs[3]  = '{LD, 3'b010, 32'h0000_0040, 32'h0,        32'h0,        -1, 1, 32'h0000_0040, 4'b1111, 32'h0,        1'b0, 32'h0000_0080};
        vecs[4]  = '{LD, 3'b011, 32'h0000_0040, 32'h0,        32'h0,        -2, 1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0000_0080};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[5]  = '{LD, 3'b010, 32'h0000_0101, 32'h0,        32'h1234_5678, -2, 1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0000_0080};
`else
        vecs[5]  = '{LD, 3'b010, 32'h0000_0101, 32'h0,        32'h1234_5678, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        1'b0, 32'h1234_5678};
`endif
        vecs[6]  = '{LD, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 0, 32'h0000_0100, 4'b1100, 32'h0,        1'b0, 32'hFFFF_8001};
        vecs[7]  = '{LD, 3'b101, 32'h0000_0100, 32'h0,        32'h8001_F00F, 0, 0, 32'h0000_0100, 4'b0011, 32'h0,        1'b0, 32'h0000_F00F};
        vecs[8]  = '{ST, 3'b000, 32'h0000_0101, 32'h1234_565A, 32'h0,        0, 0, 32'h0000_0100, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0000_F00F};
        vecs[9]  = '{ST, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,        3, 0, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0000_F00F};
        vecs[10] = '{ST, 3'b011, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,       -2, 1, 32'h0,         4'b0000, 32'h0,        1'b0, 32'h0000_F00F};
        vecs[11] = '{LD, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 0, 32'h0000_0100, 4'b0010, 32'h0,        1'b0, 32'h0000_007F};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset flags", {26'd0, busy, done, err, mem_req, mem_we, 1'b0}, 32'd0);
        check("reset be", {28'd0, mem_be}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Non-LOAD/STORE opcode with start is ignored.
        @(negedge clk);
        opcode = 7'b0110011; func3 = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("other_op busy", {30'd0, busy, mem_req}, 32'd0);
        $display("seq other_op busy=%0b", busy);

        // Start during the DONE cycle of an errored access is ignored.
        @(negedge clk);
        opcode = LD; func3 = 3'b011; addr = 32'h40; start = 1'b1;
        @(negedge clk);
        check("ill_ld done", {30'd0, done, err}, 32'd3);
        check("ill_ld req", {31'd0, mem_req}, 32'd0);
        func3 = 3'b010; addr = 32'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done ignored", {30'd0, busy, mem_req}, 32'd0);
        @(negedge clk);
        check("start_in_done still idle", {30'd0, busy, done}, 32'd0);
        $display("seq start_in_done busy=%0b", busy);

        // Reset during REQ; a late ack must not complete anything.
        @(negedge clk);
        opcode = LD; func3 = 3'b010; addr = 32'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_seq req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_seq drop", {29'd0, mem_req, busy, done}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack no done", {30'd0, done, busy}, 32'd0);
        check("late_ack rdata", rdata, 32'd0);
        $display("seq reset_in_req rdata=%08h", rdata);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage sitting directly downstream of the ALU. It takes the effective address produced by the ALU for LOAD/STORE opcodes, plus func3 and rs2 store data, and runs a req/ack transaction on the data-memory port. Stores get byte-lane steering; loads get lane extraction and sign or zero extension. A single `done` pulse with an `err` flag reports completion to the core control FSM.

## Interface
- `TIMEOUT`, default 15: maximum cycles `mem_req` is held waiting for `mem_ack` (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request from control. Sampled only in IDLE.
- `opcode` in 7: `0000011` LOAD, `0100011` STORE. Any other value with `start` is ignored.
- `func3` in 3: access size and signedness.
- `addr` in 32: effective address (ALU `Q`).
- `wdata` in 32: store data (rs2).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid only with `done`; 1 = illegal func3, misaligned access, or timeout.
- `rdata` out 32: extended load result. Holds its value until the next successful load.
- `mem_req` out 1: memory request, held high until ack or timeout.
- `mem_we` out 1: 1 = store.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte-lane enables, driven for both loads and stores.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_ack` in 1: completes the request. Ignored when `mem_req` is low.

## Operation
- FSM states: IDLE, REQ, DONE.
  - IDLE→REQ on `start` with a legal LOAD/STORE that is aligned, or misaligned with the trap feature disabled.
  - IDLE→DONE (with err) on `start` with illegal func3, or misaligned with the trap feature enabled.
  - REQ→DONE on `mem_ack`, or when the timeout expires.
  - DONE→IDLE unconditionally.
- Command latch: `opcode`, `func3`, `addr`, `wdata` are registered on accepted `start`. Inputs may change afterwards.
- Legal func3 for loads:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - 011, 110 and 111 are illegal.
- Legal func3 for stores: 000 SB, 001 SH, 010 SW. All other values are illegal.
- Byte lanes:
  - Byte: `mem_be=4'b0001<<addr[1:0]`, `mem_wdata={4{wdata[7:0]}}`.
  - Half: `mem_be=4'b0011<<{addr[1],1'b0}`, `mem_wdata={2{wdata[15:0]}}`.
  - Word: `mem_be=4'b1111`, `mem_wdata=wdata`.
- Load extraction: the lane is selected by the latched `addr[1:0]` (half uses `addr[1]`). LB/LH sign-extend; LBU/LHU zero-extend. `rdata` is registered on the `mem_ack` cycle.
- Misaligned access: half with `addr[0]=1`, or word with `addr[1:0]≠0`.
- Timeout: a counter clears on entry to REQ and increments each REQ cycle without ack. If `TIMEOUT` REQ cycles pass with no ack, go to DONE with `err=1`, drop `mem_req`, and leave `rdata` unchanged.
- Stores and errored accesses never modify `rdata`.

## Timing
- Reset values: state IDLE. `busy`, `done`, `err`, `mem_req`, `mem_we`, `mem_be` are 0. `rdata`, `mem_addr`, `mem_wdata` are 0.
- `start` at edge T (accepted): `busy` and `mem_req` are high from T+1. `mem_addr`, `mem_be`, `mem_we`, `mem_wdata` are stable for the whole of REQ.
- Ack in the first REQ cycle: `done` at T+2, `rdata` valid at T+2. Ack k cycles later: `done` at T+2+k.
- Error without memory access: `done` and `err` at T+1. `mem_req` is never asserted.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles. `done` and `err` at T+1+TIMEOUT.
- `start` while `busy` (including the DONE cycle): ignored. Next acceptance is the cycle after DONE.
- `rst` in any state: IDLE at the next edge, `mem_req` dropped, no `done` issued. A late `mem_ack` after reset is ignored.
- Outputs are registered; there is no combinational path from `mem_ack` to `mem_req`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned half/word access is trapped. It completes at T+1 with `done=1`, `err=1` and no memory request.
- Undefined: misalignment is not checked. Low address bits are truncated to the access size (half uses `addr[1]`, word uses lane 0), and the access proceeds normally.

## Test plan
- LB at `addr=0x103`, `mem_rdata=0x80FF1234`, ack first cycle: `mem_addr=0x100`, `mem_be=4'b1000`, `rdata=0xFFFFFF80` at T+2, `err=0`. Repeat as LBU: `rdata=0x00000080`.
- SH at `addr=0x202`, `wdata=0x0000ABCD`: `mem_we=1`, `mem_addr=0x200`, `mem_be=4'b1100`, `mem_wdata=0xABCDABCD`. Ack at the third REQ cycle gives `done` at T+4. `rdata` is unchanged.
- LW at `addr=0x101`:
  - With `LSU_MISALIGN_TRAP_EN`: `done`+`err` at T+1, `mem_req` never high.
  - Without it: `mem_addr=0x100`, `mem_be=4'b1111`, normal completion.
- `TIMEOUT=4`, LW at `0x40`, no ack: `mem_req` high T+1..T+4, `done`+`err` at T+5, `rdata` unchanged.
- LOAD with func3=`011`: `done`+`err` at T+1, no request. A `start` asserted during that DONE cycle is ignored.
- `rst` asserted at T+2 during REQ: T+3 shows `mem_req=0`, `busy=0`, and no `done`. `mem_ack` at T+4 has no effect.
